// File: rtl/gshare_btb_predictor_if.sv
// Fetch-side bus of the gshare/BTB predictor: request, registered prediction,
// resolved-branch update and the ready flag.
interface gshare_btb_predictor_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned GHR_BITS = 8
);
  logic                ready;
  logic                req_valid;
  logic [XLEN-1:0]     req_pc;
  logic                pred_valid;
  logic                pred_taken;
  logic [XLEN-1:0]     pred_target;
  logic                pred_btb_hit;
  logic [GHR_BITS-1:0] pred_ghr;
  logic                upd_valid;
  logic [XLEN-1:0]     upd_pc;
  logic [XLEN-1:0]     upd_target;
  logic                upd_taken;
  logic                upd_mispredict;
  logic [GHR_BITS-1:0] upd_ghr;

  modport master (
    input  ready, pred_valid, pred_taken, pred_target, pred_btb_hit, pred_ghr,
    output req_valid, req_pc, upd_valid, upd_pc, upd_target, upd_taken,
           upd_mispredict, upd_ghr
  );

  modport slave (
    output ready, pred_valid, pred_taken, pred_target, pred_btb_hit, pred_ghr,
    input  req_valid, req_pc, upd_valid, upd_pc, upd_target, upd_taken,
           upd_mispredict, upd_ghr
  );
endinterface

// File: rtl/gshare_btb_predictor.sv
// Direction/target predictor: 2-bit counter BHT (bimodal or gshare indexed) plus
// tagged direct-mapped BTB, with a self-timed table initialisation sweep.
module gshare_btb_predictor #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 256,
  parameter int unsigned BTB_ENTRIES = 64,
  parameter int unsigned TAG_BITS    = 10,
  parameter int unsigned GHR_BITS    = 8,
  parameter int unsigned MODE        = 1
) (
  input logic                    clk,
  input logic                    rst,
  gshare_btb_predictor_if.slave  bus
);

  localparam int unsigned B  = $clog2(BHT_ENTRIES);
  localparam int unsigned T  = $clog2(BTB_ENTRIES);
  localparam int unsigned N  = (BHT_ENTRIES > BTB_ENTRIES) ? BHT_ENTRIES : BTB_ENTRIES;
  localparam int unsigned NB = $clog2(N);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              state, state_next;
  logic [NB-1:0]       init_idx;
  logic [GHR_BITS-1:0] ghr, ghr_next;

  logic [1:0]          bht        [BHT_ENTRIES];
  logic                btb_valid  [BTB_ENTRIES];
  logic [TAG_BITS-1:0] btb_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]     btb_target [BTB_ENTRIES];

  logic                run, req_acc, upd_acc;
  logic [B-1:0]        req_bidx, upd_bidx;
  logic [T-1:0]        req_tidx, upd_tidx;
  logic [TAG_BITS-1:0] req_tag, upd_tag;
  logic                hit, taken;
  logic [XLEN-1:0]     target;
  logic [1:0]          upd_ctr;
  logic                unused_bits;

  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_INIT: if (init_idx == NB'(N - 1)) state_next = S_RUN;
      S_RUN:  state_next = S_RUN;
    endcase
  end

  assign run       = (state == S_RUN);
  assign bus.ready = run;
  assign req_acc   = run && bus.req_valid;
  assign upd_acc   = run && bus.upd_valid;

  assign req_tidx = bus.req_pc[T+1:2];
  assign req_tag  = bus.req_pc[T+TAG_BITS+1:T+2];
  assign upd_tidx = bus.upd_pc[T+1:2];
  assign upd_tag  = bus.upd_pc[T+TAG_BITS+1:T+2];

  // Updates index with the checkpointed history, not the live speculative GHR.
  always_comb begin
    req_bidx = bus.req_pc[B+1:2];
    upd_bidx = bus.upd_pc[B+1:2];
    if (MODE == 1) begin
      req_bidx = req_bidx ^ B'(ghr);
      upd_bidx = upd_bidx ^ B'(bus.upd_ghr);
    end
  end

  always_comb begin
    hit    = btb_valid[req_tidx] && (btb_tag[req_tidx] == req_tag);
    taken  = hit && bht[req_bidx][1];
    target = taken ? btb_target[req_tidx] : bus.req_pc + XLEN'(4);
  end

  // Mispredict restore takes priority over the speculative shift.
  always_comb begin
    ghr_next = ghr;
    if (upd_acc && bus.upd_mispredict)
      ghr_next = GHR_BITS'({bus.upd_ghr, bus.upd_taken});
    else if (req_acc && hit)
      ghr_next = GHR_BITS'({ghr, taken});
  end

  always_comb begin
    upd_ctr = bht[upd_bidx];
    if (bus.upd_taken && upd_ctr != 2'd3)
      upd_ctr = upd_ctr + 2'd1;
    else if (!bus.upd_taken && upd_ctr != 2'd0)
      upd_ctr = upd_ctr - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_idx         <= '0;
      ghr              <= '0;
      bus.pred_valid   <= 1'b0;
      bus.pred_taken   <= 1'b0;
      bus.pred_target  <= '0;
      bus.pred_btb_hit <= 1'b0;
      bus.pred_ghr     <= '0;
    end else begin
      if (!run) init_idx <= init_idx + NB'(1);
      ghr              <= ghr_next;
      bus.pred_valid   <= req_acc;
      bus.pred_taken   <= req_acc && taken;
      bus.pred_target  <= req_acc ? target : '0;
      bus.pred_btb_hit <= req_acc && hit;
      bus.pred_ghr     <= req_acc ? ghr : '0;
    end
  end

  // Tables carry no reset; the INIT sweep establishes their contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run) begin
        if (32'(init_idx) < BHT_ENTRIES) bht[init_idx[B-1:0]] <= 2'b01;
        if (32'(init_idx) < BTB_ENTRIES) btb_valid[init_idx[T-1:0]] <= 1'b0;
      end else if (upd_acc) begin
        bht[upd_bidx] <= upd_ctr;
        if (bus.upd_taken) begin
          btb_valid[upd_tidx]  <= 1'b1;
          btb_tag[upd_tidx]    <= upd_tag;
          btb_target[upd_tidx] <= bus.upd_target;
        end
      end
    end
  end

  assign unused_bits = ^{bus.req_pc, bus.upd_pc, bus.upd_ghr};

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Bench for gshare_btb_predictor: bimodal and gshare instances driven in lockstep,
// checked against an array-based reference model plus directed expectations.
module tb_gshare_btb_predictor;
  localparam int unsigned BHT = 256, BTB = 64, TAGB = 10, G = 8, N = 256, T = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gshare_btb_predictor_if #(.XLEN(32), .GHR_BITS(G)) b0 ();
  gshare_btb_predictor_if #(.XLEN(32), .GHR_BITS(G)) b1 ();

  gshare_btb_predictor #(.XLEN(32), .BHT_ENTRIES(BHT), .BTB_ENTRIES(BTB), .TAG_BITS(TAGB),
                         .GHR_BITS(G), .MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  gshare_btb_predictor #(.XLEN(32), .BHT_ENTRIES(BHT), .BTB_ENTRIES(BTB), .TAG_BITS(TAGB),
                         .GHR_BITS(G), .MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  int checks = 0;
  int failures = 0;

  bit          s_rst, s_rq, s_uv, s_utk, s_umis;
  logic [31:0] s_rpc, s_upc, s_utgt;
  logic [7:0]  s_ughr;

  int unsigned m_bht [2][BHT];
  bit          m_v   [2][BTB];
  int unsigned m_tag [2][BTB];
  logic [31:0] m_tgt [2][BTB];
  int unsigned m_ghr [2];
  bit          m_run;
  int          m_cnt;

  bit          e_valid [2], e_taken [2], e_hit [2];
  logic [31:0] e_tgt [2];
  int unsigned e_ghr [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int m);
    for (int i = 0; i < BHT; i++) m_bht[m][i] = 1;
    for (int i = 0; i < BTB; i++) m_v[m][i] = 1'b0;
    m_ghr[m] = 0;
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      int unsigned rt, rtag, rb, ut, ub, ng;
      bit hit, tk;
      e_valid[m] = 1'b0;
      if (s_rst) model_reset(m);
      else if (m_run) begin
        rt   = (s_rpc >> 2) % BTB;
        rtag = (s_rpc >> (T + 2)) % (1 << TAGB);
        rb   = ((s_rpc >> 2) % BHT) ^ (m == 1 ? m_ghr[m] : 0);
        hit  = m_v[m][rt] && (m_tag[m][rt] == rtag);
        tk   = hit && (m_bht[m][rb] >= 2);
        ng   = m_ghr[m];
        if (s_rq) begin
          e_valid[m] = 1'b1;
          e_hit[m]   = hit;
          e_taken[m] = tk;
          e_tgt[m]   = tk ? m_tgt[m][rt] : s_rpc + 32'd4;
          e_ghr[m]   = m_ghr[m];
          if (hit) ng = ((m_ghr[m] << 1) | tk) % (1 << G);
        end
        if (s_uv) begin
          ub = ((s_upc >> 2) % BHT) ^ (m == 1 ? s_ughr : 0);
          ut = (s_upc >> 2) % BTB;
          if (s_utk) begin
            if (m_bht[m][ub] < 3) m_bht[m][ub]++;
            m_v[m][ut]   = 1'b1;
            m_tag[m][ut] = (s_upc >> (T + 2)) % (1 << TAGB);
            m_tgt[m][ut] = s_utgt;
          end else if (m_bht[m][ub] > 0) m_bht[m][ub]--;
          if (s_umis) ng = ((s_ughr << 1) | s_utk) % (1 << G);
        end
        m_ghr[m] = ng;
      end
    end
    if (s_rst) begin
      m_run = 1'b0;
      m_cnt = 0;
    end else if (!m_run) begin
      m_cnt++;
      if (m_cnt == N) m_run = 1'b1;
    end
  endtask

  task automatic tick();
    logic o_rdy [2], o_val [2], o_tk [2], o_hit [2];
    logic [31:0] o_tgt [2];
    logic [7:0]  o_ghr [2];
    @(negedge clk);
    rst = s_rst;
    b0.req_valid = s_rq; b0.req_pc = s_rpc; b0.upd_valid = s_uv; b0.upd_pc = s_upc;
    b0.upd_target = s_utgt; b0.upd_taken = s_utk; b0.upd_mispredict = s_umis; b0.upd_ghr = s_ughr;
    b1.req_valid = s_rq; b1.req_pc = s_rpc; b1.upd_valid = s_uv; b1.upd_pc = s_upc;
    b1.upd_target = s_utgt; b1.upd_taken = s_utk; b1.upd_mispredict = s_umis; b1.upd_ghr = s_ughr;
    model_step();
    @(posedge clk);
    #1;
    o_rdy[0] = b0.ready; o_val[0] = b0.pred_valid; o_tk[0] = b0.pred_taken;
    o_hit[0] = b0.pred_btb_hit; o_tgt[0] = b0.pred_target; o_ghr[0] = b0.pred_ghr;
    o_rdy[1] = b1.ready; o_val[1] = b1.pred_valid; o_tk[1] = b1.pred_taken;
    o_hit[1] = b1.pred_btb_hit; o_tgt[1] = b1.pred_target; o_ghr[1] = b1.pred_ghr;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("m%0d ready", m), 32'(o_rdy[m]), 32'(m_run));
      chk($sformatf("m%0d pred_valid", m), 32'(o_val[m]), 32'(e_valid[m]));
      if (e_valid[m]) begin
        chk($sformatf("m%0d pred_btb_hit pc=%0h", m, s_rpc), 32'(o_hit[m]), 32'(e_hit[m]));
        chk($sformatf("m%0d pred_taken pc=%0h", m, s_rpc), 32'(o_tk[m]), 32'(e_taken[m]));
        chk($sformatf("m%0d pred_target pc=%0h", m, s_rpc), o_tgt[m], e_tgt[m]);
        chk($sformatf("m%0d pred_ghr pc=%0h", m, s_rpc), 32'(o_ghr[m]), e_ghr[m]);
      end
    end
  endtask

  task automatic idle();
    s_rq = 1'b0; s_uv = 1'b0;
    tick();
  endtask

  task automatic req(input logic [31:0] pc);
    s_rq = 1'b1; s_rpc = pc; s_uv = 1'b0;
    tick();
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input bit tk,
                     input bit mis, input logic [7:0] gh);
    s_rq = 1'b0; s_uv = 1'b1; s_upc = pc; s_utgt = tgt; s_utk = tk; s_umis = mis; s_ughr = gh;
    tick();
  endtask

  initial begin
    s_rst = 1'b1; s_rq = 1'b0; s_uv = 1'b0; s_utk = 1'b0; s_umis = 1'b0;
    s_rpc = '0; s_upc = '0; s_utgt = '0; s_ughr = '0;
    b0.req_valid = 1'b0; b0.upd_valid = 1'b0; b1.req_valid = 1'b0; b1.upd_valid = 1'b0;
    m_run = 1'b0; m_cnt = 0;

    // reset and init sweep
    repeat (3) idle();
    chk("reset ready", 32'(b0.ready), 0);
    chk("reset pred_valid", 32'(b0.pred_valid), 0);
    chk("reset pred_taken", 32'(b0.pred_taken), 0);
    chk("reset pred_target", b0.pred_target, 0);
    chk("reset pred_btb_hit", 32'(b0.pred_btb_hit), 0);
    chk("reset pred_ghr", 32'(b1.pred_ghr), 0);
    s_rst = 1'b0;
    repeat (N - 1) idle();
    chk("ready before N", 32'(b0.ready), 0);
    idle();
    chk("ready at N", 32'(b0.ready), 1);

    req(32'h100);
    chk("first hit", 32'(b0.pred_btb_hit), 0);
    chk("first taken", 32'(b0.pred_taken), 0);
    chk("first target", b0.pred_target, 32'h104);
    idle();
    chk("valid one cycle", 32'(b0.pred_valid), 0);

    // training
    repeat (2) upd(32'h200, 32'h180, 1'b1, 1'b0, 8'h00);
    req(32'h200);
    chk("train hit", 32'(b0.pred_btb_hit), 1);
    chk("train taken", 32'(b0.pred_taken), 1);
    chk("train target", b0.pred_target, 32'h180);
    repeat (3) upd(32'h200, 32'h180, 1'b0, 1'b0, 8'h00);
    req(32'h200);
    chk("untrain taken", 32'(b0.pred_taken), 0);
    chk("untrain target", b0.pred_target, 32'h204);

    // saturation
    repeat (10) upd(32'h300, 32'h380, 1'b1, 1'b0, 8'h00);
    upd(32'h300, 32'h380, 1'b0, 1'b0, 8'h00);
    req(32'h300);
    chk("sat3 taken", 32'(b0.pred_taken), 1);
    chk("sat3 target", b0.pred_target, 32'h380);
    repeat (4) upd(32'h300, 32'h380, 1'b0, 1'b0, 8'h00);
    upd(32'h300, 32'h380, 1'b1, 1'b0, 8'h00);
    req(32'h300);
    chk("sat0 no wrap", 32'(b0.pred_taken), 0);

    // tag alias
    upd(32'h400, 32'h480, 1'b1, 1'b0, 8'h00);
    req(32'h400 + BTB * 4);
    chk("alias hit", 32'(b0.pred_btb_hit), 0);
    chk("alias target", b0.pred_target, 32'h504);

    // gshare history
    upd(32'h800, 32'h0, 1'b0, 1'b1, 8'h00);
    repeat (2) upd(32'h640, 32'h700, 1'b1, 1'b0, 8'h00);
    repeat (2) upd(32'h640, 32'h700, 1'b1, 1'b0, 8'h01);
    req(32'h640);
    chk("gs ghr0", 32'(b1.pred_ghr), 32'h00);
    chk("gs taken0", 32'(b1.pred_taken), 1);
    chk("gs target0", b1.pred_target, 32'h700);
    req(32'h640);
    chk("gs ghr1", 32'(b1.pred_ghr), 32'h01);
    chk("gs taken1", 32'(b1.pred_taken), 1);
    s_rq = 1'b1; s_rpc = 32'h640;
    s_uv = 1'b1; s_upc = 32'h800; s_utgt = '0; s_utk = 1'b0; s_umis = 1'b1; s_ughr = 8'h05;
    tick();
    chk("gs pre-restore ghr", 32'(b1.pred_ghr), 32'h03);
    req(32'h640);
    chk("gs restored ghr", 32'(b1.pred_ghr), 32'h0A);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      s_rq   = ($urandom_range(0, 3) != 0);
      s_rpc  = 32'h1000 + ($urandom_range(0, 31) << 2) + (($urandom_range(0, 7) == 0) ? BTB * 4 : 0);
      s_uv   = ($urandom_range(0, 3) != 0);
      s_upc  = 32'h1000 + ($urandom_range(0, 31) << 2);
      s_utgt = $urandom() & 32'hFFFF_FFFC;
      s_utk  = $urandom_range(0, 1);
      s_umis = ($urandom_range(0, 3) == 0);
      s_ughr = 8'($urandom());
      tick();
    end

    // mid-operation reset
    upd(32'h200, 32'h180, 1'b1, 1'b0, 8'h00);
    req(32'h200);
    chk("pre-reset hit", 32'(b0.pred_btb_hit), 1);
    s_rst = 1'b1; s_rq = 1'b1; s_rpc = 32'h200; s_uv = 1'b0;
    tick();
    chk("midrst pred_valid", 32'(b0.pred_valid), 0);
    chk("midrst ready", 32'(b0.ready), 0);
    idle();
    s_rst = 1'b0;
    repeat (N) idle();
    chk("reinit ready", 32'(b0.ready), 1);
    req(32'h200);
    chk("reinit hit", 32'(b0.pred_btb_hit), 0);
    chk("reinit target", b0.pred_target, 32'h204);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gshare_btb_predictor.md
# gshare_btb_predictor

Parametrised next-generation fetch-stage direction and target predictor for the out-of-order RVV core. It combines a 2-bit saturating-counter BHT with a tagged, direct-mapped BTB. The BHT is indexed either bimodally or gshare-style through a speculative global history register (GHR) that is checkpointed and restored on mispredict. It sits between the fetch PC generator and the branch resolution unit, and produces one registered prediction per cycle after a self-timed table-initialisation sweep.

## Interface
Parameters:
- XLEN, 32, PC/target width
- BHT_ENTRIES, 256, BHT counters; power of 2, ≥ 4
- BTB_ENTRIES, 64, BTB entries; power of 2, ≥ 4
- TAG_BITS, 10, BTB tag width
- GHR_BITS, 8, history length; 1 ≤ GHR_BITS ≤ log2(BHT_ENTRIES)
- MODE, 1, 0 = bimodal (GHR not used for indexing), 1 = gshare

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ready  out  1  high in RUN state; requests and updates are ignored while low
- req_valid  in  1  prediction request
- req_pc  in  XLEN  fetch PC
- pred_valid  out  1  prediction valid, one cycle after an accepted request
- pred_taken  out  1  predicted taken
- pred_target  out  XLEN  predicted next PC
- pred_btb_hit  out  1  BTB tag hit for req_pc
- pred_ghr  out  GHR_BITS  GHR value used to index this prediction (checkpoint)
- upd_valid  in  1  resolved branch update
- upd_pc  in  XLEN  PC of resolved branch
- upd_target  in  XLEN  resolved taken target
- upd_taken  in  1  actual direction
- upd_mispredict  in  1  direction or target mispredicted
- upd_ghr  in  GHR_BITS  checkpoint returned with the branch

## Operation
- FSM states: INIT and RUN.
  - rst → INIT, init_idx=0, GHR=0; all outputs 0 (ready, pred_*).
  - INIT: each cycle writes BHT[init_idx]=2'b01 (when init_idx < BHT_ENTRIES) and clears BTB valid[init_idx] (when init_idx < BTB_ENTRIES), then init_idx++.
  - At init_idx = N−1, where N = max(BHT_ENTRIES, BTB_ENTRIES), the next state is RUN.
- Index functions, with B = log2(BHT_ENTRIES) and T = log2(BTB_ENTRIES):
  - bidx = pc[B+1:2], XOR zero-extended GHR when MODE=1.
  - tidx = pc[T+1:2].
  - tag = pc[T+TAG_BITS+1:T+2].
- Prediction (RUN, req_valid), computed combinationally and registered:
  - hit = valid[tidx] && tag match.
  - taken = hit && BHT[bidx][1].
  - target = taken ? btb_target[tidx] : req_pc+4 (mod 2^XLEN).
  - pred_ghr = GHR before any shift.
  - If hit, GHR ← {GHR[GHR_BITS-2:0], taken} (speculative). Non-hit requests do not shift.
- Update (RUN, upd_valid):
  - Index = upd_pc[B+1:2], XOR upd_ghr when MODE=1.
  - Counter saturating: +1 if taken and not 3; −1 if not taken and not 0.
  - If upd_taken, BTB[tidx(upd_pc)] ← {valid=1, tag, upd_target}. Not-taken updates leave the BTB unchanged.
  - If upd_mispredict, GHR ← {upd_ghr[GHR_BITS-2:0], upd_taken}.
- Simultaneous events:
  - Mispredict restore beats the speculative shift in the same cycle; the concurrent request's pred_ghr still reports the pre-restore GHR.
  - A request and an update to the same BHT/BTB index in the same cycle: the prediction uses the pre-update (old) contents.
- rst asserted mid-operation: return to INIT next cycle; pred_valid=0, ready=0; any in-flight prediction is dropped.

## Timing
- Prediction latency is 1 cycle: request at edge k → pred_* valid after edge k+1, held for one cycle only.
- Throughput is 1 request/cycle, with no back-pressure.
- pred_valid=0 on cycles following no request; pred_taken, pred_target and pred_btb_hit are don't-care then, but are driven 0 after reset.
- ready rises exactly N cycles after the first cycle with rst low (N=256 at defaults).
- Updates write tables at the edge they are presented; visible to requests from the next cycle.
- GHR wraps by shift; counters saturate at 0 and 3, with no wrap.

## Test plan
- Reset/init: assert rst 3 cycles, release → ready=0 for 256 cycles then 1. Every BHT entry is 01; first request to 0x100 gives pred_btb_hit=0, pred_taken=0, pred_target=0x104.
- Training: MODE=0, 2 taken updates (pc=0x200, target=0x180) → request 0x200 gives hit=1, taken=1, target=0x180. 3 further not-taken updates → taken=0, target=0x204.
- Saturation: 10 taken updates then 1 not-taken on pc 0x300 → still predicted taken (counter 2). 3 more not-taken → counter at 0, then holds at 0.
- Tag alias: train pc 0x400 taken; request pc 0x400+(BTB_ENTRIES·4) → hit=0, pred_target = pc+4.
- gshare history: MODE=1, hits shift GHR (taken,taken → pred_ghr 0x00 then 0x01, GHR 0x03). A same-cycle request and mispredict with upd_ghr=0x05, upd_taken=0 → GHR=0x0A, not the shifted value.
- Mid-operation reset: assert rst while a request is pending → pred_valid=0 next cycle, ready=0, full re-init, previously trained 0x200 misses.
